alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational alu instance between two requesters (0,1) with
//  round-robin arbitration. Captures the winner's operands, drives them to the
//  ALU for one cycle, registers result + NZCV flags, and returns them on the
//  winner's response channel with valid/ready handshake. Sits between decode/
//  execute clients and the shared ALU in npc.
// PARAMETERS
//  DATA_LEN  32  operand/result width; must match the attached ALU
// PORTS
//  clk          in   1         clock, all state on rising edge
//  rst_n        in   1         asynchronous active-low reset
//  reqX_valid   in   1         X=0,1: request present
//  reqX_ready   out  1         X=0,1: request accepted this cycle
//  reqX_a       in   DATA_LEN  X=0,1: operand a
//  reqX_b       in   DATA_LEN  X=0,1: operand b
//  reqX_ctl     in   3         X=0,1: ALU op code (passed through unchanged)
//  respX_valid  out  1         X=0,1: result available
//  respX_ready  in   1         X=0,1: requester takes result
//  respX_res    out  DATA_LEN  X=0,1: result (shared register, valid only with respX_valid)
//  respX_nzcv   out  4         X=0,1: {N,Z,C,V}
//  alu_a        out  DATA_LEN  to ALU operand a
//  alu_b        out  DATA_LEN  to ALU operand b
//  alu_ctl      out  3         to ALU ctl
//  alu_res      in   DATA_LEN  from ALU result
//  alu_nzcv     in   4         from ALU {N,Z,C,V}
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, last_grant=1, operand regs a/b/ctl=0,
//   res reg=0, nzcv reg=0, owner=0; all reqX_ready=0, respX_valid=0.
//   Reset mid-EXEC/RESP aborts: transaction dropped, no response issued.
//  FSM: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: grant = req0 if only req0_valid; req1 if only req1_valid; if both,
//    the requester != last_grant. reqX_ready = (state==IDLE) & grant==X &
//    reqX_valid (never both high). On handshake: latch a/b/ctl, owner=X,
//    last_grant=X, go EXEC. No valid -> stay IDLE.
//   EXEC (1 cycle): alu_a/b/ctl driven from operand regs; at cycle end latch
//    alu_res->res reg, alu_nzcv->nzcv reg; go RESP.
//   RESP: resp[owner]_valid=1, other respX_valid=0. Hold res/nzcv stable
//    until resp[owner]_ready=1; then go IDLE. Stall indefinitely otherwise.
//  alu_a/b/ctl always reflect operand regs (stable outside EXEC, no glitch
//   from requester inputs). Flags forwarded verbatim; never recomputed.
//  Latency: accept at cycle T -> respX_valid at T+2. Max throughput one op
//   per 3 cycles. reqX_ready is 0 in EXEC/RESP (no pipelining, no buffering).
//  Requests may be withdrawn before handshake; no state change results.
//  A requester holding valid while the other wins is served next (fairness:
//   at most one foreign op between request and grant).
//  respX_ready outside RESP or for non-owner is ignored.
// TESTING
//  1 Reset: rst_n low mid-RESP -> respX_valid=0 immediately, state IDLE, next
//    req0 (a=5,b=3,ctl=000) -> resp0_res=8 at T+2.
//  2 Sub: req1 a=3,b=5,ctl=001 -> resp1_res=32'hFFFFFFFE, nzcv matches ALU, resp0_valid=0.
//  3 Contention: both valid from reset -> req0 granted first, then req1; with
//    both held, grants alternate 0,1,0,1 over 4 ops.
//  4 Back-pressure: resp0_ready=0 for 10 cycles -> resp0_valid/res/nzcv
//    stable, req1_ready stays 0; ready=1 -> IDLE next cycle, req1 granted.
//  5 Operand isolation: change req0_a after handshake -> alu_a and result
//    unchanged (a=32'h7FFFFFFF,b=1,ctl=000 -> res=32'h80000000, V=1, N=1).
//  6 Withdrawal: req1_valid pulses while FSM in EXEC -> never accepted, no resp1.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters using round-robin
//   arbitration. A granted request has its operands captured, presented to
//   the ALU for one cycle, and the registered result/flags are returned on
//   the winner's response channel under a valid/ready handshake.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqX_valid/ready/a/b/ctl    X=0,1 request channel
//   respX_valid/ready/res/nzcv  X=0,1 response channel ({N,Z,C,V})
//   alu_a/b/ctl                 operands to the shared ALU (from operand regs)
//   alu_res/nzcv                result and flags from the shared ALU
module alu_arbiter #(
  parameter int unsigned DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DATA_LEN-1:0] req0_a,
  input  logic [DATA_LEN-1:0] req0_b,
  input  logic [2:0]          req0_ctl,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DATA_LEN-1:0] req1_a,
  input  logic [DATA_LEN-1:0] req1_b,
  input  logic [2:0]          req1_ctl,
  output logic                resp0_valid,
  input  logic                resp0_ready,
  output logic [DATA_LEN-1:0] resp0_res,
  output logic [3:0]          resp0_nzcv,
  output logic                resp1_valid,
  input  logic                resp1_ready,
  output logic [DATA_LEN-1:0] resp1_res,
  output logic [3:0]          resp1_nzcv,
  output logic [DATA_LEN-1:0] alu_a,
  output logic [DATA_LEN-1:0] alu_b,
  output logic [2:0]          alu_ctl,
  input  logic [DATA_LEN-1:0] alu_res,
  input  logic [3:0]          alu_nzcv
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [DATA_LEN-1:0] a_q, a_d;
  logic [DATA_LEN-1:0] b_q, b_d;
  logic [2:0]          ctl_q, ctl_d;
  logic [DATA_LEN-1:0] res_q, res_d;
  logic [3:0]          nzcv_q, nzcv_d;

  logic grant;    // requester index that would win this cycle
  logic accept0;
  logic accept1;
  logic owner_ready;

  // With both requesting, the one that did not win last goes next;
  // otherwise the single requester wins.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end
    // rst_n is folded in so neither ready can rise while reset is held.
    accept0 = rst_n && (state_q == IDLE) && req0_valid && !grant;
    accept1 = rst_n && (state_q == IDLE) && req1_valid &&  grant;
  end

  assign owner_ready = owner_q ? resp1_ready : resp0_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    ctl_d        = ctl_q;
    res_d        = res_q;
    nzcv_d       = nzcv_q;
    unique case (state_q)
      IDLE: begin
        if (accept0) begin
          a_d          = req0_a;
          b_d          = req0_b;
          ctl_d        = req0_ctl;
          owner_d      = 1'b0;
          last_grant_d = 1'b0;
          state_d      = EXEC;
        end else if (accept1) begin
          a_d          = req1_a;
          b_d          = req1_b;
          ctl_d        = req1_ctl;
          owner_d      = 1'b1;
          last_grant_d = 1'b1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_res;
        nzcv_d  = alu_nzcv;
        state_d = RESP;
      end
      RESP: begin
        if (owner_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      ctl_q        <= '0;
      res_q        <= '0;
      nzcv_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ctl_q        <= ctl_d;
      res_q        <= res_d;
      nzcv_q       <= nzcv_d;
    end
  end

  assign req0_ready  = accept0;
  assign req1_ready  = accept1;

  assign resp0_valid = (state_q == RESP) && !owner_q;
  assign resp1_valid = (state_q == RESP) &&  owner_q;
  assign resp0_res   = res_q;
  assign resp1_res   = res_q;
  assign resp0_nzcv  = nzcv_q;
  assign resp1_nzcv  = nzcv_q;

  // ALU sees only the captured operands, never the live request inputs.
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_ctl = ctl_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_ctl, req1_ctl;
  logic         resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [W-1:0] resp0_res, resp1_res;
  logic [3:0]   resp0_nzcv, resp1_nzcv;
  logic [W-1:0] alu_a, alu_b, alu_res;
  logic [2:0]   alu_ctl;
  logic [3:0]   alu_nzcv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_LEN(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctl(req0_ctl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctl(req1_ctl),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_res(resp0_res), .resp0_nzcv(resp0_nzcv),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_res(resp1_res), .resp1_nzcv(resp1_nzcv),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
    .alu_res(alu_res), .alu_nzcv(alu_nzcv)
  );

  // Reference ALU semantics: returns {res, N, Z, C, V}.
  function automatic logic [W+3:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] c);
    logic [W:0]   wide;
    logic [W-1:0] r;
    logic         cf, vf;
    cf = 1'b0;
    vf = 1'b0;
    case (c)
      3'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[W-1:0];
        cf = wide[W];
        vf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd1: begin
        r = a - b;
        cf = (a >= b);
        vf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[4:0];
      3'd6: r = a >> b[4:0];
      default: r = ($signed(a) < $signed(b)) ? 1 : 0;
    endcase
    return {r, r[W-1], (r == '0), cf, vf};
  endfunction

  // Shared ALU attached to the arbiter.
  always_comb begin
    logic [W+3:0] o;
    o = alu_ref(alu_a, alu_b, alu_ctl);
    alu_res  = o[W+3:4];
    alu_nzcv = o[3:0];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [W+3:0] exp_q0[$];
  logic [W+3:0] exp_q1[$];
  int           grant_log[$];
  bit           m_busy;
  int           m_owner, m_age, m_last;
  logic [W-1:0] m_a, m_b;
  logic [2:0]   m_ctl;

  initial begin
    m_busy = 0; m_last = 1; m_a = '0; m_b = '0; m_ctl = '0; m_owner = 0; m_age = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_resp0_valid", resp0_valid, 0);
      check("rst_resp1_valid", resp1_valid, 0);
      check("rst_req_ready", {req0_ready, req1_ready}, 0);
      m_busy = 0; m_last = 1; m_a = '0; m_b = '0; m_ctl = '0;
      exp_q0.delete(); exp_q1.delete(); grant_log.delete();
    end else begin
      check("alu_operands", {alu_ctl, alu_a, alu_b}, {m_ctl, m_a, m_b});
      if (!m_busy) begin
        int w;
        w = -1;
        if (req0_valid && req1_valid) w = (m_last == 0) ? 1 : 0;
        else if (req0_valid) w = 0;
        else if (req1_valid) w = 1;
        check("idle_resp_valid", {resp0_valid, resp1_valid}, 0);
        check("req0_ready", req0_ready, w == 0);
        check("req1_ready", req1_ready, w == 1);
        if (w == 0) begin
          exp_q0.push_back(alu_ref(req0_a, req0_b, req0_ctl));
          m_a = req0_a; m_b = req0_b; m_ctl = req0_ctl;
        end else if (w == 1) begin
          exp_q1.push_back(alu_ref(req1_a, req1_b, req1_ctl));
          m_a = req1_a; m_b = req1_b; m_ctl = req1_ctl;
        end
        if (w >= 0) begin
          m_busy = 1; m_owner = w; m_age = 0; m_last = w;
          grant_log.push_back(w);
        end
      end else begin
        m_age++;
        check("busy_req_ready", {req0_ready, req1_ready}, 0);
        if (m_age == 1) begin
          check("exec_resp_valid", {resp0_valid, resp1_valid}, 0);
        end else begin
          check("resp_valid", {resp1_valid, resp0_valid}, (m_owner == 1) ? 2 : 1);
          if (m_owner == 0) begin
            if (exp_q0.size() == 0) check("q0_nonempty", 0, 1);
            else begin
              check("resp0_res", resp0_res, exp_q0[0][W+3:4]);
              check("resp0_nzcv", resp0_nzcv, exp_q0[0][3:0]);
              if (resp0_ready) begin void'(exp_q0.pop_front()); m_busy = 0; end
            end
          end else begin
            if (exp_q1.size() == 0) check("q1_nonempty", 0, 1);
            else begin
              check("resp1_res", resp1_res, exp_q1[0][W+3:4]);
              check("resp1_nzcv", resp1_nzcv, exp_q1[0][3:0]);
              if (resp1_ready) begin void'(exp_q1.pop_front()); m_busy = 0; end
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int x, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] c);
    bit ok;
    ok = 0;
    if (x == 0) begin req0_a = a; req0_b = b; req0_ctl = c; req0_valid = 1; end
    else        begin req1_a = a; req1_b = b; req1_ctl = c; req1_valid = 1; end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = (x == 0) ? req0_ready : req1_ready;
    end
    if (!ok) check("handshake_timeout", 0, 1);
    cyc();
    if (x == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    cyc(2);
    rst_n = 1;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_b = '0; req0_ctl = '0;
    req1_a = '0; req1_b = '0; req1_ctl = '0;
    resp0_ready = 1; resp1_ready = 1;
    cyc(3);
    rst_n = 1;
    cyc();

    // Reset asserted while a response is held, then a fresh add.
    resp0_ready = 0;
    send(0, 32'd1, 32'd2, 3'd0);
    cyc(3);
    check("resp0_valid_before_reset", resp0_valid, 1);
    do_reset();
    resp0_ready = 1;
    send(0, 32'd5, 32'd3, 3'd0);
    cyc(3);

    // Subtraction on requester 1.
    send(1, 32'd3, 32'd5, 3'd1);
    cyc(3);

    // Contention from reset: both held, grants must alternate.
    do_reset();
    req0_a = 32'd10; req0_b = 32'd20; req0_ctl = 3'd0; req0_valid = 1;
    req1_a = 32'd7;  req1_b = 32'd9;  req1_ctl = 3'd1; req1_valid = 1;
    cyc(14);
    req0_valid = 0; req1_valid = 0;
    cyc(4);
    check("grant_count_ge4", grant_log.size() >= 4, 1);
    if (grant_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("grant_order", grant_log[i], i % 2);
    end

    // Back-pressure on requester 0 while requester 1 waits.
    do_reset();
    resp0_ready = 0;
    req1_a = 32'd100; req1_b = 32'd1; req1_ctl = 3'd4; req1_valid = 1;
    send(0, 32'hDEADBEEF, 32'h0000FFFF, 3'd2);
    cyc(12);
    resp0_ready = 1;
    for (int i = 0; i < 10 && !req1_ready; i++) @(negedge clk);
    check("req1_granted_after_bp", req1_ready, 1);
    cyc();
    req1_valid = 0;
    cyc(4);

    // Operand isolation: inputs change right after the handshake.
    send(0, 32'h7FFFFFFF, 32'd1, 3'd0);
    req0_a = 32'h12345678;
    req0_b = 32'hFFFFFFFF;
    cyc(4);

    // Withdrawal: requester 1 pulses valid during EXEC only.
    send(0, 32'd9, 32'd4, 3'd5);
    req1_a = 32'd1; req1_b = 32'd1; req1_valid = 1;
    cyc();
    req1_valid = 0;
    cyc(4);
    check("no_resp1_after_withdraw", exp_q1.size(), 0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      req0_valid  = ($urandom_range(0, 3) != 0);
      req1_valid  = ($urandom_range(0, 3) != 0);
      req0_a      = ($urandom_range(0, 7) == 0) ? 32'h7FFFFFFF : $urandom;
      req0_b      = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      req1_a      = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      req1_b      = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
      req0_ctl    = 3'($urandom_range(0, 7));
      req1_ctl    = 3'($urandom_range(0, 7));
      resp0_ready = ($urandom_range(0, 1) != 0);
      resp1_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end

    req0_valid = 0; req1_valid = 0;
    resp0_ready = 1; resp1_ready = 1;
    cyc(8);
    check("final_q0_empty", exp_q0.size(), 0);
    check("final_q1_empty", exp_q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
